// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op encoding, FSM states and width defaults for the HI/LO unit
package mult_div_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int OP_WIDTH  = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// mult_div_unit_div_step: one combinational restoring-division iteration
module mult_div_unit_div_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial    = {rem, in_bit};
    assign diff     = trial - {1'b0, divisor};
    // a borrow out of the top bit means the trial subtraction failed: restore
    assign q_bit    = !diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;
    localparam int MW = WIDTH + MUL_STEP;

    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) || (WIDTH % MUL_STEP) != 0 ||
        (WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_param
        $error("mult_div_unit: illegal WIDTH/MUL_STEP combination");
    end

    muldiv_state_t    state, state_n;
    muldiv_op_t       op_t;
    logic [W2-1:0]    acc, acc_mul, step_n, prod_s, fast_p, fast_s;
    logic [WIDTH-1:0] opnd, mag_a, mag_b, rem_n, lo_div, hi_div, fin_hi, fin_lo;
    logic [MW-1:0]    mul_sum;
    logic [CW-1:0]    cnt, last_cnt;
    logic             neg_q, neg_r, accept, last, is_mul, is_div, sa, sb, q_bit, fast_pend;

    assign op_t   = muldiv_op_t'(op);
    assign busy   = state != IDLE;
    assign accept = start && !busy && !flush;
    assign is_mul = op_t == OP_MULT || op_t == OP_MULTU;
    assign is_div = op_t == OP_DIV || op_t == OP_DIVU;
    assign sa     = (op_t == OP_MULT || op_t == OP_DIV) && rs[WIDTH-1];
    assign sb     = (op_t == OP_MULT || op_t == OP_DIV) && rt[WIDTH-1];
    assign mag_a  = sa ? -rs : rs;
    assign mag_b  = sb ? -rt : rt;

    assign last_cnt = state == MUL ? CW'(WIDTH / MUL_STEP - 1) : CW'(WIDTH - 1);
    assign last     = cnt == last_cnt;

    // acc = {partial product, unretired multiplier bits}; shift right by MUL_STEP each cycle
    assign mul_sum = MW'(acc[W2-1:WIDTH]) + MW'(opnd) * MW'(acc[MUL_STEP-1:0]);
    assign acc_mul = W2'({mul_sum, acc[WIDTH-1:0]} >> MUL_STEP);

    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc[W2-1:WIDTH]),
        .in_bit   (acc[WIDTH-1]),
        .divisor  (opnd),
        .rem_next (rem_n),
        .q_bit    (q_bit)
    );

    assign step_n = state == MUL ? acc_mul : {rem_n, acc[WIDTH-2:0], q_bit};
    assign prod_s = neg_q ? -step_n : step_n;
    assign lo_div = neg_q ? -step_n[WIDTH-1:0] : step_n[WIDTH-1:0];
    assign hi_div = neg_r ? -step_n[W2-1:WIDTH] : step_n[W2-1:WIDTH];
    assign fin_hi = state == MUL ? prod_s[W2-1:WIDTH] : hi_div;
    assign fin_lo = state == MUL ? prod_s[WIDTH-1:0] : lo_div;
    assign fast_s = neg_q ? -fast_p : fast_p;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign fast_p = W2'(acc[WIDTH-1:0]) * W2'(opnd);
    always_ff @(posedge clk) begin
        fast_pend <= !rst && accept && is_mul;
    end
`else
    localparam bit FAST_MUL = 1'b0;
    assign fast_p    = '0;
    assign fast_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (busy)
            state_n = (flush || last) ? IDLE : state;
        else if (accept && is_div)
            state_n = DIV;
        else if (accept && is_mul && !FAST_MUL)
            state_n = MUL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= busy ? cnt + 1'b1 : '0;
            if (busy && !flush)
                acc <= step_n;
            if (accept && (is_mul || is_div)) begin
                acc   <= {{WIDTH{1'b0}}, mag_a};
                opnd  <= mag_b;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end
            if (busy && last && !flush) begin
                hi   <= fin_hi;
                lo   <= fin_lo;
                done <= 1'b1;
            end
            if (fast_pend && !flush) begin
                hi   <= fast_s[W2-1:WIDTH];
                lo   <= fast_s[WIDTH-1:0];
                done <= 1'b1;
            end
            // a move issued after a pending fast product is younger and must win
            if (accept && op_t == OP_MTHI)
                hi <= rs;
            if (accept && op_t == OP_MTLO)
                lo <= rs;
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS R2000 core, serving MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Parametrised in datapath width, and in multiply radix through MUL_STEP.
- Sits beside the ALU in EX. The pipeline stalls on busy; MFHI/MFLO read the hi/lo ports directly.
- Supports flush, which aborts an in-flight operation on exception.

Parameters:
- WIDTH, Constants::WIDTH (32): operand and HI/LO width. Must be even and >= 4.
- MUL_STEP, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4; WIDTH % MUL_STEP must be 0. Elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request valid for op.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- rs  in  WIDTH  operand A / dividend / MTxx data.
- rt  in  WIDTH  operand B / divisor.
- flush  in  1  abort the current operation.
- busy  out  1  operation in flight; requests are refused.
- done  out  1  one-cycle pulse when HI/LO take a mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0. Reset wins over every other input, including mid-operation; no partial result is kept.
- States:
  - IDLE -> MUL on start with op 0/1.
  - IDLE -> DIV on start with op 2/3.
  - MUL/DIV -> IDLE on the last iteration, or on flush.
- Acceptance: a request is taken only when start=1, busy=0 and flush=0.
  - start while busy is ignored. A bench assertion flags it.
  - flush and start in the same cycle: flush wins and the request is dropped.
- MTHI/MTLO: accepted in IDLE only. The target register is written at the next edge, with no busy and no done.
- Latency: with acceptance at edge 0, busy=1 for N cycles.
  - Multiply: N = WIDTH/MUL_STEP.
  - Divide: N = WIDTH.
  - At edge N, HI/LO are written, done=1 for one cycle and busy=0. A new start is accepted in that same done cycle.
- Signed ops: operands are converted to magnitudes at acceptance and the unsigned core runs on them.
  - Product sign = sign(rs) ^ sign(rt).
  - Quotient sign = sign(rs) ^ sign(rt).
  - Remainder sign = sign(rs).
  - Negation is applied at the final edge.
- Multiply: shift-add, 2*WIDTH-bit product. HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring, one bit per cycle. LO = quotient, HI = remainder.
- Divide by zero (defined, not trapped):
  - DIVU: LO = all ones, HI = rs.
  - DIV: quotient and remainder are the unsigned-core results on the magnitudes, then sign-corrected by the rules above.
- Overflow: DIV of most-negative by -1 gives LO = most-negative and HI = 0. This is the natural magnitude result; no special case.
- flush while busy: busy=0 at the next edge, no done, HI/LO keep their pre-operation values.
- hi/lo are registered outputs and change only on the edges listed above.

Optional Feature:
- MULDIV_FAST_MUL_EN:
  - Defined: MULT/MULTU use a combinational WIDTH x WIDTH multiplier. HI/LO are written at edge 1, done pulses in cycle 1, and busy is never asserted for multiply. MUL_STEP is ignored.
  - Undefined: the iterative multiply with MUL_STEP radix as specified.
  - Division is unchanged either way.

Decomposition:
- Package MulDiv:
  - typedef enum muldiv_op_t, the 3-bit op encoding.
  - typedef enum muldiv_state_t, with IDLE/MUL/DIV.
  - localparam OP_WIDTH = 3.
  - Width defaults come from Constants::WIDTH.
- Sub-module div_step: combinational single restoring-division iteration (partial remainder, divisor -> next remainder, quotient bit), WIDTH-parametrised.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_STEP=1 -> busy exactly 32 cycles, done at cycle 32, HI=0xFFFFFFFE, LO=0x00000001. Repeat with MUL_STEP=4 -> busy 8 cycles, same result.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5. DIVU 100 / 7 -> LO=14, HI=2.
- MTHI 0x1234, MTLO 0x5678, then DIVU 9/3 with flush at busy cycle 10 -> busy=0 next cycle, no done, HI=0x1234, LO=0x5678. A start asserted during busy is ignored.
- Mid-multiply rst, and start+flush in the same cycle -> after rst, hi=lo=0 and busy=0; the start+flush request is dropped and busy stays 0.
